lamp_fpu_div_seq: RTL
=====================

// Module: lamp_fpu_div_seq
// PURPOSE
//  Initiator-side sequencer for the fractional Goldschmidt divider. Accepts packed floats
//  a/b, does sign/exponent/special-case logic and issues mantissas on div_* port. Waits for
//  the quotient, normalises and rounds it (RNE), then returns a packed float with IEEE flags.
//  Sits between the FPU op dispatch and the fractional divider; the divider is external.
// PARAMETERS
//  LAMP_FLOAT_DW   16   packed float width
//  LAMP_FLOAT_E_DW 8    exponent width
//  LAMP_FLOAT_F_DW 7    stored fraction width (F)
//  LAMP_FLOAT_BIAS 127  exponent bias
// PORTS
//  clk          in   1      clock
//  rst          in   1      synchronous, active-high reset
//  in_valid_i   in   1      operand pair valid
//  in_ready_o   out  1      sequencer can accept (IDLE only)
//  a_i          in   16     dividend, packed {s,e,f}
//  b_i          in   16     divisor, packed
//  out_valid_o  out  1      result valid, held until out_ready_i
//  out_ready_i  in   1      consumer accepts result
//  res_o        out  16     quotient, packed
//  flags_o      out  5      {invalid,div_by_zero,overflow,underflow,inexact}
//  div_do_o     out  1      one-cycle start pulse to divider
//  div_n_o      out  1+F    dividend mantissa {1,f_a}
//  div_d_o      out  1+F    divisor mantissa {1,f_b}
//  div_res_i    in   2(1+F) quotient: 2 integer bits, 2F fraction bits
//  div_valid_i  in   1      one-cycle quotient strobe
// BEHAVIOUR
//  Reset: state IDLE; in_ready_o=1, out_valid_o=0, res_o=0, flags_o=0, div_do_o=0, div_n/d=0.
//  FSM: IDLE -accept-> ISSUE | DONE (special); ISSUE -> WAIT; WAIT -div_valid_i-> NORM;
//   NORM -> DONE; DONE -out_ready_i-> IDLE. in_ready_o = (state==IDLE); no same-cycle
//   DONE->accept.
//  Accept (IDLE & in_valid_i): register s=s_a^s_b, exp=e_a-e_b+BIAS (10-bit signed), mantissas.
//  Denormal inputs (e==0) flushed to signed zero before classification.
//  Special cases (DONE next cycle, divider not started): any NaN, 0/0, inf/inf -> 0x7FC0,
//   invalid; finite/0 -> signed inf, div_by_zero; inf/finite -> signed inf;
//   0/finite and finite/inf -> signed zero. No other flags set.
//  ISSUE: div_do_o=1 for exactly one cycle, div_n_o/div_d_o stable from ISSUE until NORM.
//  WAIT: unbounded; div_valid_i outside WAIT is ignored. Quotient captured on div_valid_i.
//  NORM: if q[2F] set: mant=q[2F-1 -: F], G/R/sticky from lower bits; else shift left 1,
//   exp-=1. RNE: round up if G&(R|S|lsb). Mantissa carry-out -> mant=0, exp+=1.
//   inexact = G|R|S. exp>=255 -> signed inf, overflow|inexact. exp<=0 -> signed zero,
//   underflow|inexact (flush-to-zero, no denormal output).
//  DONE: out_valid_o=1; res_o/flags_o stable until accepted.
//  Latency (normal path): out_valid_o rises 2 cycles after div_valid_i; special path:
//   1 cycle after accept.
//  Reset mid-operation: return to IDLE in the reset cycle, drop pending work, no out_valid.
// STRUCTURE
//  Shared package: float field widths, BIAS, qNaN/inf constants, classification typedef
//   {ZERO,NORM,INF,NAN}, FSM state enum, flag bit indices.
//  One sub-module natural: lamp_fpu_div_round (combinational normalise + RNE + exponent range
//   check), reused by multiply.
// TESTING (bench provides a divider responder model returning exact truncated quotient after
//  N cycles, N randomised 1..20)
//  0x3FC0/0x3F80 (1.5/1.0) -> res 0x3FC0, flags 0, exactly one div_do_o pulse.
//  0x3F80/0x4040 (1/3) -> res 0x3EAB, inexact=1 only.
//  0x3F80/0x0000 -> 0x7F80 div_by_zero; 0x0000/0x0000 -> 0x7FC0 invalid; div_do_o never set.
//  0x7F00/0x0080 -> 0x7F80 overflow+inexact; 0x0080/0x7F00 -> 0x0000 underflow+inexact.
//  out_ready_i low 5 cycles in DONE -> res_o/flags_o stable, in_ready_o=0, then IDLE next.
//  rst asserted in WAIT, stale div_valid_i next cycle -> no out_valid_o, next op correct.

Source files
------------

// File: rtl/lamp_fpu_div_seq_pkg.sv
// rtl/lamp_fpu_div_seq_pkg.sv - shared float widths, constants, classes, states and flag indices
package lamp_fpu_div_seq_pkg;

   localparam int LAMP_FLOAT_DW   = 16;
   localparam int LAMP_FLOAT_E_DW = 8;
   localparam int LAMP_FLOAT_F_DW = 7;
   localparam int LAMP_FLOAT_BIAS = 127;

   // Mantissa with hidden bit, and the divider quotient (2 integer + 2F fraction bits)
   localparam int MANT_W = LAMP_FLOAT_F_DW + 1;
   localparam int Q_W    = 2 * MANT_W;

   // Working exponent is signed and wide enough for e_a - e_b + BIAS plus normalise/round steps
   localparam int EXP_W = 10;
   localparam logic signed [EXP_W-1:0] EXP_BIAS = EXP_W'(LAMP_FLOAT_BIAS);
   localparam logic signed [EXP_W-1:0] EXP_ONE  = EXP_W'(1);
   localparam logic signed [EXP_W-1:0] EXP_INF  = EXP_W'((1 << LAMP_FLOAT_E_DW) - 1);

   localparam logic [LAMP_FLOAT_DW-1:0] QNAN = 16'h7FC0;

   localparam int FLAG_W         = 5;
   localparam int FLAG_INVALID   = 4;
   localparam int FLAG_DIV_ZERO  = 3;
   localparam int FLAG_OVERFLOW  = 2;
   localparam int FLAG_UNDERFLOW = 1;
   localparam int FLAG_INEXACT   = 0;

   typedef enum logic [1:0] {
      CLS_ZERO,
      CLS_NORM,
      CLS_INF,
      CLS_NAN
   } float_cls_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_NORM,
      ST_DONE
   } div_state_t;

   // Denormals (e==0) are treated as zero: the unit flushes them before any decision
   function automatic float_cls_t classify(input logic [LAMP_FLOAT_E_DW-1:0] e,
                                           input logic [LAMP_FLOAT_F_DW-1:0] f);
      float_cls_t c;
      if (e == '0) begin
         c = CLS_ZERO;
      end else if (e == '1) begin
         c = (f == '0) ? CLS_INF : CLS_NAN;
      end else begin
         c = CLS_NORM;
      end
      return c;
   endfunction

endpackage

// File: rtl/lamp_fpu_div_round.sv
// rtl/lamp_fpu_div_round.sv - normalise a 2.2F mantissa result, round to nearest even, range check
module lamp_fpu_div_round
   import lamp_fpu_div_seq_pkg::*;
(
   input  logic [Q_W-1:0]              i_q,
   input  logic signed [EXP_W-1:0]     i_exp,
   input  logic                        i_sign,
   output logic [LAMP_FLOAT_DW-1:0]    o_res,
   output logic [FLAG_W-1:0]           o_flags
);

   localparam int F = LAMP_FLOAT_F_DW;
   localparam int E = LAMP_FLOAT_E_DW;

   logic [F-1:0]            w_mant;
   logic                    w_g;
   logic                    w_r;
   logic                    w_s;
   logic signed [EXP_W-1:0] w_exp_n;
   logic signed [EXP_W-1:0] w_exp_r;
   logic [F:0]              w_sum;
   logic                    w_up;

   // Pick the window below the leading one: [2,4) shifts right (product use), [0.5,1) shifts left
   always_comb begin
      w_mant  = '0;
      w_g     = 1'b0;
      w_r     = 1'b0;
      w_s     = 1'b0;
      w_exp_n = i_exp;
      if (i_q[2*F+1]) begin
         w_mant  = i_q[2*F -: F];
         w_g     = i_q[F];
         w_r     = i_q[F-1];
         w_s     = |i_q[F-2:0];
         w_exp_n = i_exp + EXP_ONE;
      end else if (i_q[2*F]) begin
         w_mant  = i_q[2*F-1 -: F];
         w_g     = i_q[F-1];
         w_r     = i_q[F-2];
         w_s     = |i_q[F-3:0];
         w_exp_n = i_exp;
      end else begin
         w_mant  = i_q[2*F-2 -: F];
         w_g     = i_q[F-2];
         w_r     = i_q[F-3];
         w_s     = |i_q[F-4:0];
         w_exp_n = i_exp - EXP_ONE;
      end
   end

   // RNE increment; a carry out of the fraction leaves it zero and bumps the exponent
   always_comb begin
      w_up    = w_g & (w_r | w_s | w_mant[0]);
      w_sum   = {1'b0, w_mant} + {{F{1'b0}}, w_up};
      w_exp_r = w_sum[F] ? (w_exp_n + EXP_ONE) : w_exp_n;
      o_flags = '0;
      o_res   = {i_sign, w_exp_r[E-1:0], w_sum[F-1:0]};
      o_flags[FLAG_INEXACT] = w_g | w_r | w_s;
      if (w_exp_r >= EXP_INF) begin
         o_res = {i_sign, {E{1'b1}}, {F{1'b0}}};
         o_flags[FLAG_OVERFLOW] = 1'b1;
         o_flags[FLAG_INEXACT]  = 1'b1;
      end else if (w_exp_r < EXP_ONE) begin
         o_res = {i_sign, {(E+F){1'b0}}};
         o_flags[FLAG_UNDERFLOW] = 1'b1;
         o_flags[FLAG_INEXACT]   = 1'b1;
      end
   end

endmodule

// File: rtl/lamp_fpu_div_seq.sv
// rtl/lamp_fpu_div_seq.sv - float divide sequencer around an external fractional divider
module lamp_fpu_div_seq
   import lamp_fpu_div_seq_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid_i,
   output logic                        in_ready_o,
   input  logic [LAMP_FLOAT_DW-1:0]    a_i,
   input  logic [LAMP_FLOAT_DW-1:0]    b_i,
   output logic                        out_valid_o,
   input  logic                        out_ready_i,
   output logic [LAMP_FLOAT_DW-1:0]    res_o,
   output logic [FLAG_W-1:0]           flags_o,
   output logic                        div_do_o,
   output logic [MANT_W-1:0]           div_n_o,
   output logic [MANT_W-1:0]           div_d_o,
   input  logic [Q_W-1:0]              div_res_i,
   input  logic                        div_valid_i
);

   localparam int F = LAMP_FLOAT_F_DW;
   localparam int E = LAMP_FLOAT_E_DW;

   div_state_t              r_state;
   div_state_t              w_state_nxt;
   logic                    r_sign;
   logic signed [EXP_W-1:0] r_exp;
   logic [MANT_W-1:0]       r_div_n;
   logic [MANT_W-1:0]       r_div_d;
   logic [Q_W-1:0]          r_q;
   logic [LAMP_FLOAT_DW-1:0] r_res;
   logic [FLAG_W-1:0]       r_flags;

   logic                    w_sa;
   logic                    w_sb;
   logic                    w_sign;
   logic [E-1:0]            w_ea;
   logic [E-1:0]            w_eb;
   logic [F-1:0]            w_fa;
   logic [F-1:0]            w_fb;
   float_cls_t              w_ca;
   float_cls_t              w_cb;
   logic signed [EXP_W-1:0] w_ea_s;
   logic signed [EXP_W-1:0] w_eb_s;
   logic signed [EXP_W-1:0] w_exp_in;
   logic                    w_special;
   logic [LAMP_FLOAT_DW-1:0] w_sp_res;
   logic [FLAG_W-1:0]       w_sp_flags;
   logic [LAMP_FLOAT_DW-1:0] w_rnd_res;
   logic [FLAG_W-1:0]       w_rnd_flags;
   logic                    w_accept;

   assign w_sa     = a_i[LAMP_FLOAT_DW-1];
   assign w_sb     = b_i[LAMP_FLOAT_DW-1];
   assign w_sign   = w_sa ^ w_sb;
   assign w_ea     = a_i[E+F-1:F];
   assign w_eb     = b_i[E+F-1:F];
   assign w_fa     = a_i[F-1:0];
   assign w_fb     = b_i[F-1:0];
   assign w_ca     = classify(w_ea, w_fa);
   assign w_cb     = classify(w_eb, w_fb);
   assign w_ea_s   = {{(EXP_W-E){1'b0}}, w_ea};
   assign w_eb_s   = {{(EXP_W-E){1'b0}}, w_eb};
   assign w_exp_in = w_ea_s - w_eb_s + EXP_BIAS;
   assign w_accept = (r_state == ST_IDLE) && in_valid_i;

   assign in_ready_o  = (r_state == ST_IDLE);
   assign out_valid_o = (r_state == ST_DONE);
   assign div_do_o    = (r_state == ST_ISSUE);
   assign res_o       = r_res;
   assign flags_o     = r_flags;
   assign div_n_o     = r_div_n;
   assign div_d_o     = r_div_d;

   // Operand pairs that never need the divider, resolved straight from the classes
   always_comb begin
      w_special  = 1'b1;
      w_sp_res   = '0;
      w_sp_flags = '0;
      if ((w_ca == CLS_NAN) || (w_cb == CLS_NAN) ||
          ((w_ca == CLS_ZERO) && (w_cb == CLS_ZERO)) ||
          ((w_ca == CLS_INF) && (w_cb == CLS_INF))) begin
         w_sp_res = QNAN;
         w_sp_flags[FLAG_INVALID] = 1'b1;
      end else if (w_ca == CLS_INF) begin
         w_sp_res = {w_sign, {E{1'b1}}, {F{1'b0}}};
      end else if (w_cb == CLS_ZERO) begin
         w_sp_res = {w_sign, {E{1'b1}}, {F{1'b0}}};
         w_sp_flags[FLAG_DIV_ZERO] = 1'b1;
      end else if ((w_ca == CLS_ZERO) || (w_cb == CLS_INF)) begin
         w_sp_res = {w_sign, {(E+F){1'b0}}};
      end else begin
         w_special = 1'b0;
      end
   end

   lamp_fpu_div_round u_round (
      .i_q     (r_q),
      .i_exp   (r_exp),
      .i_sign  (r_sign),
      .o_res   (w_rnd_res),
      .o_flags (w_rnd_flags)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state: specials skip the divider, DONE must drain to IDLE before the next accept
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (in_valid_i) w_state_nxt = w_special ? ST_DONE : ST_ISSUE;
         ST_ISSUE: w_state_nxt = ST_WAIT;
         ST_WAIT:  if (div_valid_i) w_state_nxt = ST_NORM;
         ST_NORM:  w_state_nxt = ST_DONE;
         ST_DONE:  if (out_ready_i) w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // Operand capture, quotient capture and result registers held through DONE
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sign  <= 1'b0;
         r_exp   <= '0;
         r_div_n <= '0;
         r_div_d <= '0;
         r_q     <= '0;
         r_res   <= '0;
         r_flags <= '0;
      end else begin
         if (w_accept) begin
            r_sign  <= w_sign;
            r_exp   <= w_exp_in;
            r_div_n <= {1'b1, w_fa};
            r_div_d <= {1'b1, w_fb};
            if (w_special) begin
               r_res   <= w_sp_res;
               r_flags <= w_sp_flags;
            end
         end
         if ((r_state == ST_WAIT) && div_valid_i) begin
            r_q <= div_res_i;
         end
         if (r_state == ST_NORM) begin
            r_res   <= w_rnd_res;
            r_flags <= w_rnd_flags;
         end
      end
   end

endmodule
